// File: rtl/lib_arbiter_pkg.sv
// Shared types and default geometry for the event readout sequencer.
// Only the state encoding and default array size live here.
package lib_arbiter_pkg;

    localparam int DEF_ROWS = 4;
    localparam int DEF_COLS = 4;
    localparam int DEF_TS_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REFRESH,
        ST_ROW_REQ,
        ST_ROW_WAIT,
        ST_COL_SCAN,
        ST_DONE
    } readout_state_e;

endpackage

// File: rtl/col_first_set.sv
// Lowest-set-bit encoder for one snapshot row.
// Column 0 has the highest priority; any_o flags a non-empty row.
module col_first_set #(
    parameter int COLS    = 4,
    parameter int COL_ADD = 2
) (
    input  logic [COLS-1:0]    bits_i,
    output logic [COL_ADD-1:0] index_o,
    output logic               any_o
);

    // Walking down from the top leaves the lowest set column as the final winner.
    always_comb begin
        index_o = '0;
        any_o   = 1'b0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (bits_i[c]) begin
                index_o = COL_ADD'(c);
                any_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/event_readout_ctrl.sv
// Frame readout sequencer: snapshots the event matrix, drives the row arbiter, streams (row, col).
// Optional build macro EVT_TIMESTAMP_EN adds a frame timestamp output evt_ts_o.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start_i; snapshot taken on start
// REFRESH   | one-cycle row_refresh_o to re-init the arbiter mask
// ROW_REQ   | advance the arbiter, or finish when no rows are pending
// ROW_WAIT  | capture the granted row index
// COL_SCAN  | emit events of the selected row, lowest column first
// DONE      | one-cycle frame_done_o
module event_readout_ctrl
    import lib_arbiter_pkg::*;
#(
    parameter int ROWS    = DEF_ROWS,
    parameter int COLS    = DEF_COLS,
    parameter int ROW_ADD = $clog2(ROWS),
    parameter int COL_ADD = $clog2(COLS)
`ifdef EVT_TIMESTAMP_EN
    ,
    parameter int TS_W    = DEF_TS_W
`endif
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic [ROWS*COLS-1:0] events_i,
    output logic [ROWS-1:0]      row_req_o,
    output logic                 row_enable_o,
    output logic                 row_refresh_o,
    input  logic [ROW_ADD-1:0]   row_xadd_i,
    output logic                 evt_valid_o,
    input  logic                 evt_ready_i,
    output logic [ROW_ADD-1:0]   evt_row_o,
    output logic [COL_ADD-1:0]   evt_col_o,
    output logic                 busy_o,
    output logic                 frame_done_o
`ifdef EVT_TIMESTAMP_EN
    ,
    output logic [TS_W-1:0]      evt_ts_o
`endif
);

    readout_state_e state_q, state_d;

    logic [ROWS*COLS-1:0] evt_ff;
    logic [ROWS*COLS-1:0] clear_mask;
    logic [ROW_ADD-1:0]   row_sel;
    logic [COLS-1:0]      row_bits;
    logic [COLS-1:0]      col_onehot;
    logic [COL_ADD-1:0]   col_idx;
    logic                 col_any;
    logic                 grant_nonempty;
    logic                 evt_hs;

    // Request vector shrinks as rows drain, so a served row is never re-granted.
    always_comb begin
        row_req_o = '0;
        for (int r = 0; r < ROWS; r++) begin
            row_req_o[r] = |evt_ff[r*COLS +: COLS];
        end
    end

    always_comb begin
        row_bits       = '0;
        grant_nonempty = 1'b0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_sel == ROW_ADD'(r)) begin
                row_bits = evt_ff[r*COLS +: COLS];
            end
            if (row_xadd_i == ROW_ADD'(r)) begin
                grant_nonempty = row_req_o[r];
            end
        end
    end

    col_first_set #(
        .COLS    (COLS),
        .COL_ADD (COL_ADD)
    ) u_col_first_set (
        .bits_i  (row_bits),
        .index_o (col_idx),
        .any_o   (col_any)
    );

    always_comb begin
        col_onehot = COLS'(1) << col_idx;
        clear_mask = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_sel == ROW_ADD'(r)) begin
                clear_mask[r*COLS +: COLS] = col_onehot;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        row_refresh_o = 1'b0;
        row_enable_o  = 1'b0;
        evt_valid_o   = 1'b0;
        evt_row_o     = '0;
        evt_col_o     = '0;
        frame_done_o  = 1'b0;
        busy_o        = (state_q != ST_IDLE);
        evt_hs        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_REFRESH;
            end
            ST_REFRESH: begin
                row_refresh_o = 1'b1;
                state_d       = ST_ROW_REQ;
            end
            ST_ROW_REQ: begin
                if (row_req_o == '0) begin
                    state_d = ST_DONE;
                end else begin
                    row_enable_o = 1'b1;
                    state_d      = ST_ROW_WAIT;
                end
            end
            ST_ROW_WAIT: begin
                state_d = grant_nonempty ? ST_COL_SCAN : ST_ROW_REQ;
            end
            ST_COL_SCAN: begin
                evt_valid_o = col_any;
                evt_row_o   = row_sel;
                evt_col_o   = col_idx;
                evt_hs      = col_any && evt_ready_i;
                if (!col_any) begin
                    state_d = ST_ROW_REQ;
                end else if (evt_hs && ((row_bits & ~col_onehot) == '0)) begin
                    state_d = ST_ROW_REQ;
                end
            end
            ST_DONE: begin
                frame_done_o = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            evt_ff  <= '0;
            row_sel <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && start_i) begin
                evt_ff <= events_i;
            end else if (evt_hs) begin
                evt_ff <= evt_ff & ~clear_mask;
            end
            if (state_q == ST_ROW_WAIT) begin
                row_sel <= row_xadd_i;
            end
        end
    end

`ifdef EVT_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;
    logic [TS_W-1:0] ts_frame;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ts_cnt   <= '0;
            ts_frame <= '0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
            if (state_q == ST_IDLE && start_i) begin
                ts_frame <= ts_cnt;
            end
        end
    end

    assign evt_ts_o = ts_frame;
`endif

endmodule
